trng_conditioner: RTL

- Consumer side of the ring-oscillator entropy source.
- Controls the oscillator's stop input and samples its raw bit through a synchronizer.
- Decimates the samples, runs an online repetition-count health test, removes bias with a von Neumann debiaser, and packs the result into WIDTH-bit words.
- Words leave on a valid/ready stream toward the key/seed consumer.

---
 rtl/trng_pkg.sv | 16 +
 rtl/trng_vn_debias.sv | 32 +++
 rtl/trng_conditioner.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG conditioner: FSM states, alarm_cause
// bit positions and the adaptive-proportion window length.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        COLLECT = 2'd2,
        ALARM   = 2'd3
    } state_t;

    localparam int CAUSE_RCT  = 0;
    localparam int CAUSE_APT  = 1;
    localparam int APT_WINDOW = 512;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs strobed samples in order, 01 -> 0, 10 -> 1,
// equal pairs are dropped. clear restarts pairing at the first sample.
module trng_vn_debias (
    input  logic clock,
    input  logic reset_n,
    input  logic sample,
    input  logic sample_strobe,
    input  logic clear,
    output logic bit_out,
    output logic bit_valid
);

    logic first_reg;
    logic half_reg;

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            first_reg <= 1'b0;
            half_reg  <= 1'b0;
        end else if (sample_strobe) begin
            if (!half_reg) begin
                first_reg <= sample;
            end
            half_reg <= !half_reg;
        end
    end

    // The emitted bit is the first sample of an unequal pair.
    assign bit_valid = sample_strobe && half_reg && (first_reg != sample);
    assign bit_out   = first_reg;

endmodule

// File: rtl/trng_conditioner.sv
// TRNG conditioner: oscillator control, raw-bit synchronizer, decimation, RCT health
// test, von Neumann debias and word packing. Define TRNG_APT_EN to add the APT.
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_DIV    = 4,
    parameter int WARMUP_CYCLES = 64,
    parameter int RCT_CUTOFF    = 32,
    parameter int APT_CUTOFF    = 410
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             raw_bit,
    output logic             ro_hold,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             alarm,
    output logic [1:0]       alarm_cause,
    input  logic             alarm_clear
);

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int DEC_W  = $clog2(SAMPLE_DIV + 1);
    localparam int RCT_W  = $clog2(RCT_CUTOFF + 1);
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(SAMPLE_DIV - 1);
    localparam logic [RCT_W-1:0]  RCT_LAST  = RCT_W'(RCT_CUTOFF - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WIDTH);

    state_t            state_reg, state_next;
    logic              sync0_reg, sync1_reg;
    logic [WARM_W-1:0] warm_cnt_reg;
    logic [DEC_W-1:0]  dec_cnt_reg;
    logic              prev_reg, have_prev_reg;
    logic [RCT_W-1:0]  rct_cnt_reg;
    logic [WIDTH-1:0]  shift_reg, data_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic              valid_reg, alarm_reg;
    logic [1:0]        cause_reg;
    logic              sample, strobe, same, rct_trip, apt_trip, trip;
    logic              collecting, load, bit_out, bit_valid;

    assign sample     = sync1_reg;
    assign strobe     = (state_reg == COLLECT) && (dec_cnt_reg == DEC_LAST);
    assign same       = have_prev_reg && (sample == prev_reg);
    assign rct_trip   = strobe && same && (rct_cnt_reg >= RCT_LAST);
    assign trip       = rct_trip || apt_trip;
    // Anything leaving or outside COLLECT discards the datapath state.
    assign collecting = (state_reg == COLLECT) && (state_next == COLLECT);
    assign load       = (bit_cnt_reg == CNT_FULL) && (!valid_reg || ready);

    assign ro_hold     = (state_reg == IDLE) || (state_reg == ALARM);
    assign data        = data_reg;
    assign valid       = valid_reg;
    assign alarm       = alarm_reg;
    assign alarm_cause = cause_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = WARMUP;
            WARMUP: begin
                if (!enable)                       state_next = IDLE;
                else if (warm_cnt_reg == WARM_LAST) state_next = COLLECT;
            end
            COLLECT: begin
                if (trip)         state_next = ALARM;
                else if (!enable) state_next = IDLE;
            end
            ALARM:   if (alarm_clear) state_next = enable ? WARMUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync0_reg     <= 1'b0;
            sync1_reg     <= 1'b0;
            warm_cnt_reg  <= '0;
            dec_cnt_reg   <= '0;
            prev_reg      <= 1'b0;
            have_prev_reg <= 1'b0;
            rct_cnt_reg   <= '0;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            alarm_reg     <= 1'b0;
            cause_reg     <= 2'b00;
        end else begin
            sync0_reg    <= raw_bit;
            sync1_reg    <= sync0_reg;
            warm_cnt_reg <= (state_reg == WARMUP && state_next == WARMUP) ?
                            warm_cnt_reg + WARM_W'(1) : '0;
            dec_cnt_reg  <= (!collecting || strobe) ? '0 : dec_cnt_reg + DEC_W'(1);

            if (!collecting) begin
                prev_reg      <= 1'b0;
                have_prev_reg <= 1'b0;
                rct_cnt_reg   <= '0;
            end else if (strobe) begin
                prev_reg      <= sample;
                have_prev_reg <= 1'b1;
                rct_cnt_reg   <= same ? rct_cnt_reg + RCT_W'(1) : RCT_W'(1);
            end

            if (!collecting) begin
                shift_reg   <= '0;
                bit_cnt_reg <= '0;
                valid_reg   <= 1'b0;
            end else if (load) begin
                data_reg    <= shift_reg;
                valid_reg   <= 1'b1;
                shift_reg   <= bit_valid ? WIDTH'(bit_out) : '0;
                bit_cnt_reg <= bit_valid ? CNT_W'(1) : '0;
            end else begin
                if (valid_reg && ready) valid_reg <= 1'b0;
                // A full shift register with a stalled output drops new bits.
                if (bit_valid && (bit_cnt_reg != CNT_FULL)) begin
                    shift_reg   <= {shift_reg[WIDTH-2:0], bit_out};
                    bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                end
            end

            if (state_reg == ALARM && alarm_clear) begin
                alarm_reg <= 1'b0;
                cause_reg <= 2'b00;
            end else if (trip) begin
                alarm_reg <= 1'b1;
                if (rct_trip) cause_reg[CAUSE_RCT] <= 1'b1;
                if (apt_trip) cause_reg[CAUSE_APT] <= 1'b1;
            end
        end
    end

`ifdef TRNG_APT_EN
    localparam int APT_IW = $clog2(APT_WINDOW);
    localparam int APT_CW = $clog2(APT_WINDOW + 1);
    localparam logic [APT_IW-1:0] APT_LAST = APT_IW'(APT_WINDOW - 1);

    logic [APT_IW-1:0] apt_idx_reg;
    logic [APT_CW-1:0] apt_cnt_reg, apt_cnt_next;
    logic              apt_key_reg;

    // The first sample of each window is the key and counts itself.
    assign apt_cnt_next = (apt_idx_reg == '0) ? APT_CW'(1) :
                          apt_cnt_reg + APT_CW'(sample == apt_key_reg);
    assign apt_trip     = strobe && (apt_idx_reg == APT_LAST) &&
                          (apt_cnt_next > APT_CW'(APT_CUTOFF));

    always_ff @(posedge clock) begin
        if (!reset_n || !collecting) begin
            apt_idx_reg <= '0;
            apt_cnt_reg <= '0;
            apt_key_reg <= 1'b0;
        end else if (strobe) begin
            if (apt_idx_reg == '0) apt_key_reg <= sample;
            apt_cnt_reg <= apt_cnt_next;
            apt_idx_reg <= (apt_idx_reg == APT_LAST) ? '0 : apt_idx_reg + APT_IW'(1);
        end
    end
`else
    // APT_CUTOFF has no consumer without the proportion test.
    logic apt_unused;
    assign apt_trip   = 1'b0;
    assign apt_unused = (APT_CUTOFF != 0);
`endif

    trng_vn_debias u_debias (
        .clock         (clock),
        .reset_n       (reset_n),
        .sample        (sample),
        .sample_strobe (strobe),
        .clear         (state_reg != COLLECT),
        .bit_out       (bit_out),
        .bit_valid     (bit_valid)
    );

endmodule
